fake_node_mpi_core: RTL and testbench

FAKE_NODE_MPI_CORE -- requirements
Module: fake_node_mpi

---
 rtl/fake_node_pkg.sv | 18 +
 rtl/fake_node_fifo.sv | 50 +++++
 rtl/fake_node_mpi_core.sv | 95 +++++++++
 tb/tb_fake_node_mpi_core.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fake_node_pkg.sv
// fake_node_pkg: shared parameters, flit layout and LFSR step for the fake MPI node
package fake_node_pkg;
    localparam int DATA_W = 64;
    localparam int CREDITS = 4;
    localparam logic [31:0] LFSR_SEED = 32'h0000_ACE1;
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef struct packed {
        logic [7:0]  dest;
        logic [7:0]  src;
        logic [15:0] seq;
        logic [31:0] payload;
    } flit_t;

    function automatic logic [31:0] lfsr_next(input logic [31:0] cur);
        return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 32'h0);
    endfunction
endpackage

// File: rtl/fake_node_fifo.sv
// fake_node_fifo: small synchronous FIFO buffering received flits
module fake_node_fifo #(
    parameter int W = 64,
    parameter int DEPTH = 4
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push, do_pop;

    assign full    = cnt == CW'(DEPTH);
    assign empty   = cnt == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
        return p == AW'(DEPTH - 1) ? '0 : p + AW'(1);
    endfunction

    // storage needs no reset: cnt decides which entries are visible
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    // read/write pointers and occupancy
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= inc(wr_ptr);
            if (do_pop) rd_ptr <= inc(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end
endmodule

// File: rtl/fake_node_mpi_core.sv
// fake_node_mpi_core: credit-based flit generator plus checking receiver
module fake_node_mpi_core #(
    parameter int DATA_W = fake_node_pkg::DATA_W,
    parameter int CREDITS = fake_node_pkg::CREDITS
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic [31:0]       rank_i,
    input  logic [31:0]       dest_i,
    input  logic [31:0]       origin_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              yummy_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              yummy_i,
    input  logic              rx_stall_i,
    output logic              err_o,
    output logic [31:0]       rx_count_o
);
    import fake_node_pkg::*;

    localparam int CW = $clog2(CREDITS + 1);

    logic [CW-1:0]     credits;
    logic [15:0]       tx_seq, rx_seq;
    logic [31:0]       tx_lfsr, rx_lfsr;
    logic              send, yummy_ok, push, pop, full, empty, bad;
    logic [DATA_W-1:0] rx_dout;
    flit_t             tx_flit, rx_flit;
    logic              unused_bits;

    assign send        = credits != '0;
    assign yummy_ok    = yummy_i && credits != CW'(CREDITS);
    assign tx_flit     = {dest_i[7:0], rank_i[7:0], tx_seq, tx_lfsr};
    assign push        = valid_i && !full;
    assign pop         = !empty && !rx_stall_i;
    assign rx_flit     = 64'(rx_dout);
    assign bad         = rx_flit.dest != rank_i[7:0] || rx_flit.src != origin_i[7:0] ||
                         rx_flit.seq != rx_seq || rx_flit.payload != rx_lfsr;
    assign unused_bits = ^{rank_i[31:8], dest_i[31:8], origin_i[31:8]};

    fake_node_fifo #(.W(DATA_W), .DEPTH(CREDITS)) u_fifo (
        .clk_i  (clk_i),
        .rstn_i (rstn_i),
        .push   (push),
        .pop    (pop),
        .din    (data_i),
        .dout   (rx_dout),
        .full   (full),
        .empty  (empty)
    );

    // credit counter and outgoing flit generator
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            credits <= CW'(CREDITS);
            valid_o <= 1'b0;
            data_o  <= '0;
            tx_seq  <= '0;
            tx_lfsr <= LFSR_SEED;
        end else begin
            credits <= credits - CW'(send) + CW'(yummy_ok);
            valid_o <= send;
            if (send) begin
                data_o  <= DATA_W'(tx_flit);
                tx_seq  <= tx_seq + 16'd1;
                tx_lfsr <= lfsr_next(tx_lfsr);
            end
        end
    end

    // consumer side: credit return, pop count and expected-flit tracking
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) begin
            yummy_o    <= 1'b0;
            rx_count_o <= '0;
            rx_seq     <= '0;
            rx_lfsr    <= LFSR_SEED;
        end else begin
            yummy_o <= pop;
            if (pop) begin
                rx_count_o <= rx_count_o + 32'd1;
                rx_seq     <= rx_seq + 16'd1;
                rx_lfsr    <= lfsr_next(rx_lfsr);
            end
        end
    end

    // sticky error: credit overflow, RX overflow or a bad popped flit
    always_ff @(posedge clk_i or posedge rstn_i) begin
        if (rstn_i) err_o <= 1'b0;
        else err_o <= err_o | (yummy_i && !yummy_ok) | (valid_i && full) | (pop && bad);
    end
endmodule

// File: tb/tb_fake_node_mpi_core.sv
// tb_fake_node_mpi_core: randomized scoreboard bench for the fake MPI node
module tb_fake_node_mpi_core;
    localparam int DW = 64;
    localparam int CR = 4;
    localparam logic [31:0] SEED = 32'h0000_ACE1;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic          clk = 0, rst = 1;
    logic [31:0]   rank = 0, dest = 0, origin = 0;
    logic          lb = 0, tb_valid = 0, tb_yummy = 0, stall = 0;
    logic [DW-1:0] tb_data = '0;
    logic          valid_i, yummy_i, yummy_o, valid_o, err_o;
    logic [DW-1:0] data_i, data_o;
    logic [31:0]   rx_count_o;
    logic [15:0]   inj_seq = 0;
    logic [31:0]   inj_lfsr = SEED;
    int            n_chk = 0, n_fail = 0;

    logic [63:0] txq[$], rxq[$];
    int          m_cr = CR;
    bit          m_valid, m_yummy, m_err;
    logic [15:0] m_tseq, m_rseq;
    logic [31:0] m_tlfsr, m_rlfsr, m_cnt;

    always #5 clk = ~clk;

    assign valid_i = lb ? valid_o : tb_valid;
    assign data_i  = lb ? data_o : tb_data;
    assign yummy_i = lb ? yummy_o : tb_yummy;

    fake_node_mpi_core #(.DATA_W(DW), .CREDITS(CR)) dut (
        .clk_i      (clk),
        .rstn_i     (rst),
        .rank_i     (rank),
        .dest_i     (dest),
        .origin_i   (origin),
        .valid_i    (valid_i),
        .data_i     (data_i),
        .yummy_o    (yummy_o),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .yummy_i    (yummy_i),
        .rx_stall_i (stall),
        .err_o      (err_o),
        .rx_count_o (rx_count_o)
    );

    function automatic logic [31:0] step(input logic [31:0] x);
        logic [31:0] y;
        y = x >> 1;
        if (x[0]) y = y ^ TAPS;
        return y;
    endfunction

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    // reference model and monitor: compare at negedge, then predict the next edge
    always @(negedge clk) begin : mon
        bit send, yok, full;
        logic [63:0] f;
        if (rst) begin
            txq.delete();
            rxq.delete();
            m_cr = CR;
            m_valid = 0;
            m_yummy = 0;
            m_err = 0;
            m_tseq = 0;
            m_rseq = 0;
            m_tlfsr = SEED;
            m_rlfsr = SEED;
            m_cnt = 0;
        end else begin
            chk("valid_o", valid_o, m_valid);
            if (valid_o && txq.size() > 0) chk("data_o", data_o, txq.pop_front());
            chk("yummy_o", yummy_o, m_yummy);
            chk("rx_count_o", rx_count_o, m_cnt);
            chk("err_o", err_o, m_err);
            send = m_cr > 0;
            m_valid = send;
            if (send) begin
                txq.push_back({dest[7:0], rank[7:0], m_tseq, m_tlfsr});
                m_tseq++;
                m_tlfsr = step(m_tlfsr);
            end
            yok = yummy_i && m_cr != CR;
            if (yummy_i && !yok) m_err = 1;
            m_cr = m_cr - int'(send) + int'(yok);
            full = rxq.size() == CR;
            m_yummy = rxq.size() > 0 && !stall;
            if (m_yummy) begin
                f = rxq.pop_front();
                if (f[63:56] != rank[7:0] || f[55:48] != origin[7:0] || f[47:32] != m_rseq || f[31:0] != m_rlfsr)
                    m_err = 1;
                m_rseq++;
                m_rlfsr = step(m_rlfsr);
                m_cnt++;
            end
            if (valid_i) begin
                if (full) m_err = 1;
                else rxq.push_back(data_i);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic l);
        rst = 1;
        lb = l;
        tb_valid = 0;
        tb_yummy = 0;
        stall = 0;
        inj_seq = 0;
        inj_lfsr = SEED;
        repeat (2) tick();
        rst = 0;
    endtask

    task automatic inject_good();
        tb_data = {rank[7:0], origin[7:0], inj_seq, inj_lfsr};
        tb_valid = 1;
        inj_seq++;
        inj_lfsr = step(inj_lfsr);
    endtask

    initial begin
        int n, gaps, bad, b;
        logic [31:0] prev;
        logic [63:0] d;
        // reset state, then a credit return while credits are full
        rank = $urandom; dest = $urandom; origin = $urandom;
        do_reset(0);
        chk("rst_valid_o", valid_o, 0);
        chk("rst_yummy_o", yummy_o, 0);
        chk("rst_data_o", data_o, 0);
        chk("rst_err_o", err_o, 0);
        chk("rst_rx_count", rx_count_o, 0);
        tb_yummy = 1; tick(); tb_yummy = 0;
        chk("yummy_at_full_err", err_o, 1);
        // no credit returns: four flits, then one more per yummy
        do_reset(0);
        n = 0;
        repeat (10) begin
            tick();
            if (valid_o) begin chk("no_yummy_seq", data_o[47:32], n); n++; end
        end
        chk("pulses_no_yummy", n, 4);
        tb_yummy = 1; tick(); tb_yummy = 0;
        n = 0;
        repeat (6) begin
            tick();
            if (valid_o) begin chk("extra_seq", data_o[47:32], 4); n++; end
        end
        chk("pulses_after_yummy", n, 1);
        chk("err_after_yummy", err_o, 0);
        // stalled consumer with five injected flits
        do_reset(0);
        stall = 1;
        n = 0;
        repeat (5) begin inject_good(); tick(); n += int'(yummy_o); end
        tb_valid = 0;
        repeat (3) begin tick(); n += int'(yummy_o); end
        chk("stall_yummy", n, 0);
        chk("overflow_err", err_o, 1);
        chk("stall_count", rx_count_o, 0);
        stall = 0;
        n = 0;
        repeat (8) begin tick(); n += int'(yummy_o); end
        chk("drain_yummy", n, 4);
        chk("drain_count", rx_count_o, 4);
        // random RX traffic, stalls and legal credit returns
        rank = $urandom; origin = $urandom; dest = $urandom;
        do_reset(0);
        n = 0;
        repeat (300) begin
            stall = ($urandom_range(3) == 0);
            tb_yummy = (m_cr < CR) && ($urandom_range(2) == 0);
            if (rxq.size() < CR && $urandom_range(1) == 0) begin inject_good(); n++; end
            else tb_valid = 0;
            tick();
        end
        tb_valid = 0; tb_yummy = 0; stall = 0;
        repeat (8) tick();
        chk("rand_count", rx_count_o, n);
        chk("rand_err", err_o, 0);
        d = {rank[7:0], origin[7:0], inj_seq, inj_lfsr};
        b = $urandom_range(63);
        d[b] = ~d[b];
        tb_data = d; tb_valid = 1; tick(); tb_valid = 0;
        repeat (4) tick();
        chk("corrupt_err", err_o, 1);
        // loopback, matching ranks
        rank = $urandom; dest = rank; origin = rank;
        do_reset(1);
        gaps = 0; bad = 0; prev = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (i >= 1 && !valid_o) gaps++;
            if (i >= 3 && rx_count_o <= prev) bad++;
            prev = rx_count_o;
        end
        chk("lb_gaps", gaps, 0);
        chk("lb_nonincr", bad, 0);
        chk("lb_err", err_o, 0);
        chk("lb_count", rx_count_o, 198);
        // loopback with a wrong origin
        rank = $urandom; dest = rank; origin = {rank[31:8], rank[7:0] + 8'd1};
        do_reset(1);
        tick(); tick();
        chk("orig_err_before_pop", err_o, 0);
        tick();
        chk("orig_err_after_pop", err_o, 1);
        // reset mid-stream
        rank = $urandom; dest = rank; origin = rank;
        do_reset(1);
        repeat (20) tick();
        rst = 1;
        #1;
        chk("mid_rst_valid_o", valid_o, 0);
        chk("mid_rst_yummy_o", yummy_o, 0);
        chk("mid_rst_data_o", data_o, 0);
        chk("mid_rst_err_o", err_o, 0);
        chk("mid_rst_rx_count", rx_count_o, 0);
        tick(); tick();
        rst = 0;
        n = 0;
        while (!valid_o && n < 5) begin tick(); n++; end
        chk("post_rst_valid", valid_o, 1);
        chk("post_rst_flit", data_o[47:0], {16'h0, SEED});
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
